uart_tx: RTL and testbench



---
 rtl/uart_tx_pkg.sv | 30 +++
 rtl/uart_tx_fifo.sv | 60 ++++++
 rtl/uart_tx.sv | 174 +++++++++++++++++
 tb/tb_uart_tx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and bit timing.
// Kept separate so the receive side can import the same constants.
package uart_tx_pkg;

    localparam int TICKS_PER_BIT = 16;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [7:0] d, input int mode);
        logic x;
        x = ^d;
        if (mode == PARITY_ODD) begin
            return ~x;
        end else begin
            return x;
        end
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for the UART transmitter: push/pop with full/empty flags
// and a one-cycle overflow pulse when a push is refused.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             do_push, do_pop;

    assign full     = (cnt_q == CW'(DEPTH));
    assign empty    = (cnt_q == {CW{1'b0}});
    assign dout     = mem_q[rd_q];
    assign overflow = ovf_q;

    // Next-state pointers and count; full is judged on the pre-edge count.
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_d    = do_push ? (wr_q + PW'(1)) : wr_q;
        rd_d    = do_pop  ? (rd_q + PW'(1)) : rd_q;
        cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
        ovf_d   = push && full;
    end

    // Pointer/count/flag registers and storage write.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= {PW{1'b0}};
            rd_q  <= {PW{1'b0}};
            cnt_q <= {CW{1'b0}};
            ovf_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            if (do_push) begin
                mem_q[wr_q] <= din;
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter on the 16x-baud clock: FIFO-buffered bytes are sent as
// start bit, LSB-first data, optional parity and one or two stop bits.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clkx16,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 load,
    output logic                 tx,
    output logic                 full,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);

    localparam logic [3:0] LAST_TICK = 4'(TICKS_PER_BIT - 1);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [3:0]           tick_q, tick_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 pop_s;
    logic                 tick_end_s;
    logic                 fifo_empty_s;
    logic [DATA_BITS-1:0] fifo_dout_s;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clkx16),
        .reset    (reset),
        .push     (load),
        .pop      (pop_s),
        .din      (data),
        .dout     (fifo_dout_s),
        .full     (full),
        .empty    (fifo_empty_s),
        .overflow (overflow)
    );

    assign tick_end_s = (tick_q == LAST_TICK);

    // Frame sequencing; tx is driven from the current state so it lags by one cycle.
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        parity_d = parity_q;
        done_d   = 1'b0;
        pop_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tick_d = 4'd0;
                bit_d  = 4'd0;
                if (!fifo_empty_s) begin
                    pop_s    = 1'b1;
                    shreg_d  = fifo_dout_s;
                    parity_d = parity_bit(8'(fifo_dout_s), PARITY);
                    state_d  = ST_START;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_START: begin
                tick_d = tick_q + 4'd1;
                if (tick_end_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                tick_d = tick_q + 4'd1;
                if (tick_end_s) begin
                    shreg_d = shreg_q >> 1'b1;
                    if (bit_q == LAST_DATA) begin
                        bit_d   = 4'd0;
                        state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                tick_d = tick_q + 4'd1;
                if (tick_end_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                tick_d = tick_q + 4'd1;
                if (tick_end_s && (bit_q == LAST_STOP)) begin
                    done_d = 1'b1;
                    bit_d  = 4'd0;
                    // Chain straight into the next frame when one is waiting.
                    if (!fifo_empty_s) begin
                        pop_s    = 1'b1;
                        shreg_d  = fifo_dout_s;
                        parity_d = parity_bit(8'(fifo_dout_s), PARITY);
                        state_d  = ST_START;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end else if (tick_end_s) begin
                    bit_d = bit_q + 4'd1;
                end else begin
                    bit_d = bit_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tick_d  = 4'd0;
                bit_d   = 4'd0;
            end
        endcase

        case (state_q)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_q[0];
            ST_PARITY: tx_d = parity_q;
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase

        busy_d = (state_q != ST_IDLE) || !fifo_empty_s;
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clkx16) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            tick_q   <= 4'd0;
            bit_q    <= 4'd0;
            shreg_q  <= {DATA_BITS{1'b0}};
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign tx   = tx_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four configurations driven with directed
// and random bytes, compared cycle by cycle against a frame-level model.
module tb_uart_tx;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] load_v, tx_v, full_v, busy_v, done_v, ovf_v;
    logic [7:0] data_a [4];

    int par_cfg  [4] = '{0, 2, 1, 0};
    int stop_cfg [4] = '{1, 1, 1, 2};

    int tests = 0;
    int fails = 0;

    logic [7:0] bq[$];
    logic       cap_tx[$];
    logic       cap_done[$];

    always #5 clk = ~clk;

    uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_0 (
        .clkx16(clk), .reset(reset), .data(data_a[0]), .load(load_v[0]), .tx(tx_v[0]),
        .full(full_v[0]), .busy(busy_v[0]), .done(done_v[0]), .overflow(ovf_v[0]));
    uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_1 (
        .clkx16(clk), .reset(reset), .data(data_a[1]), .load(load_v[1]), .tx(tx_v[1]),
        .full(full_v[1]), .busy(busy_v[1]), .done(done_v[1]), .overflow(ovf_v[1]));
    uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_2 (
        .clkx16(clk), .reset(reset), .data(data_a[2]), .load(load_v[2]), .tx(tx_v[2]),
        .full(full_v[2]), .busy(busy_v[2]), .done(done_v[2]), .overflow(ovf_v[2]));
    uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut_3 (
        .clkx16(clk), .reset(reset), .data(data_a[3]), .load(load_v[3]), .tx(tx_v[3]),
        .full(full_v[3]), .busy(busy_v[3]), .done(done_v[3]), .overflow(ovf_v[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int first_done();
        for (int i = 0; i < cap_done.size(); i++) begin
            if (cap_done[i] === 1'b1) return i;
        end
        return -1;
    endfunction

    function automatic int count_done();
        int n = 0;
        foreach (cap_done[i]) if (cap_done[i] === 1'b1) n++;
        return n;
    endfunction

    // Loads bq on consecutive edges (edge N = first load edge), samples after each edge N+m.
    task automatic run_test(input string tag, input int sel, input int rst_at);
        int k, L, nf, cnt, T;
        logic fb, after_rst, e_tx, e_done, e_busy, e_ovf, e_full, pb;
        logic [7:0] b;
        logic [7:0] acc[$];
        logic full_exp[$], ovf_exp[$], exp_tx[$], bits[$];
        int bad[5], first[5];
        for (int i = 0; i < 5; i++) begin bad[i] = 0; first[i] = -1; end

        k   = bq.size();
        L   = 16 * (1 + 8 + ((par_cfg[sel] != 0) ? 1 : 0) + stop_cfg[sel]);
        cnt = 0;
        // FIFO occupancy: one push per edge while not full, the first pop one edge later.
        for (int i = 0; i < k; i++) begin
            fb = (cnt == DEPTH);
            ovf_exp.push_back(fb);
            if (!fb) begin acc.push_back(bq[i]); cnt++; end
            if (i == 1) cnt--;
            full_exp.push_back(cnt == DEPTH);
        end
        if (k == 1) cnt--;
        nf = acc.size();

        exp_tx.push_back(1'b1);
        exp_tx.push_back(1'b1);
        foreach (acc[f]) begin
            b = acc[f];
            bits.delete();
            bits.push_back(1'b0);
            for (int j = 0; j < 8; j++) bits.push_back(b[j]);
            pb = ^b;
            if (par_cfg[sel] == 2) bits.push_back(pb);
            if (par_cfg[sel] == 1) bits.push_back(~pb);
            for (int s = 0; s < stop_cfg[sel]; s++) bits.push_back(1'b1);
            foreach (bits[j]) for (int t = 0; t < 16; t++) exp_tx.push_back(bits[j]);
        end

        T = 2 + L * nf + 8;
        cap_tx.delete();
        cap_done.delete();
        for (int m = 0; m < T; m++) begin
            reset        = (m == rst_at);
            load_v[sel]  = (m < k);
            data_a[sel]  = (m < k) ? bq[m] : 8'h00;
            @(negedge clk);
            cap_tx.push_back(tx_v[sel]);
            cap_done.push_back(done_v[sel]);
            after_rst = (rst_at >= 0) && (m >= rst_at);
            e_tx   = after_rst ? 1'b1 : ((m < exp_tx.size()) ? exp_tx[m] : 1'b1);
            e_done = 1'b0;
            for (int f = 0; f < nf; f++) if (!after_rst && m == 1 + L * (f + 1)) e_done = 1'b1;
            e_busy = !after_rst && (m >= 1) && (m <= 1 + L * nf);
            e_ovf  = !after_rst && (m < k) && ovf_exp[m];
            e_full = after_rst ? 1'b0 : ((m < k) ? full_exp[m] : (cnt == DEPTH));
            if (tx_v[sel] !== e_tx)   begin bad[0]++; if (first[0] < 0) first[0] = m; end
            if (done_v[sel] !== e_done) begin bad[1]++; if (first[1] < 0) first[1] = m; end
            if (busy_v[sel] !== e_busy) begin bad[2]++; if (first[2] < 0) first[2] = m; end
            if (ovf_v[sel] !== e_ovf)  begin bad[3]++; if (first[3] < 0) first[3] = m; end
            if ((m < L) && (full_v[sel] !== e_full)) begin bad[4]++; if (first[4] < 0) first[4] = m; end
        end
        reset       = 1'b0;
        load_v[sel] = 1'b0;
        chk($sformatf("%s tx bad cycles (first %0d)", tag, first[0]), bad[0], 0);
        chk($sformatf("%s done bad cycles (first %0d)", tag, first[1]), bad[1], 0);
        chk($sformatf("%s busy bad cycles (first %0d)", tag, first[2]), bad[2], 0);
        chk($sformatf("%s overflow bad cycles (first %0d)", tag, first[3]), bad[3], 0);
        chk($sformatf("%s full bad cycles (first %0d)", tag, first[4]), bad[4], 0);
    endtask

    initial begin
        int sel, k;
        reset  = 1'b1;
        load_v = 4'b0000;
        for (int i = 0; i < 4; i++) data_a[i] = 8'h00;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("reset tx[%0d]", s), tx_v[s], 1);
            chk($sformatf("reset full[%0d]", s), full_v[s], 0);
            chk($sformatf("reset busy[%0d]", s), busy_v[s], 0);
            chk($sformatf("reset done[%0d]", s), done_v[s], 0);
            chk($sformatf("reset overflow[%0d]", s), ovf_v[s], 0);
        end
        reset = 1'b0;
        @(negedge clk);

        bq.delete(); bq.push_back(8'h55);
        run_test("t1_0x55", 0, -1);
        chk("t1 done index", first_done(), 161);
        chk("t1 done count", count_done(), 1);
        chk("t1 data bit0", cap_tx[26], 1);
        chk("t1 data bit1", cap_tx[42], 0);

        bq.delete(); bq.push_back(8'h07);
        run_test("t2_even", 1, -1);
        chk("t2 even parity bit", cap_tx[154], 1);
        chk("t2 even done index", first_done(), 177);

        bq.delete(); bq.push_back(8'h07);
        run_test("t2_odd", 2, -1);
        chk("t2 odd parity bit", cap_tx[154], 0);
        chk("t2 odd done index", first_done(), 177);

        bq.delete(); bq.push_back(8'hA1); bq.push_back(8'h3C); bq.push_back(8'hFF);
        run_test("t3_b2b", 0, -1);
        chk("t3 done count", count_done(), 3);
        chk("t3 last stop of frame 1", cap_tx[161], 1);
        chk("t3 start of frame 2", cap_tx[162], 0);

        bq.delete();
        for (int i = 0; i < 6; i++) bq.push_back(8'($urandom));
        run_test("t4_overflow", 0, -1);
        chk("t4 done count", count_done(), 5);

        bq.delete(); bq.push_back(8'h00);
        run_test("t5_stop2", 3, -1);
        chk("t5 last data bit", cap_tx[145], 0);
        chk("t5 first stop cycle", cap_tx[146], 1);
        chk("t5 last stop cycle", cap_tx[177], 1);
        chk("t5 done index", first_done(), 177);

        bq.delete();
        for (int i = 0; i < 3; i++) bq.push_back(8'($urandom));
        run_test("t6_reset", 0, 72);
        chk("t6 done count", count_done(), 0);

        for (int r = 0; r < 4; r++) begin
            sel = int'($urandom_range(3, 0));
            k   = int'($urandom_range(6, 1));
            bq.delete();
            for (int i = 0; i < k; i++) bq.push_back(8'($urandom));
            run_test($sformatf("rand%0d_sel%0d_k%0d", r, sel, k), sel, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
